// File: rtl/xcvr_reset_seq.sv
// Transceiver PHY reset sequencer: independent TX and RX channel FSMs plus a shared recovery counter.
// Build macro XCVR_RST_TIMEOUT_EN adds per-channel timeout counters and the ERROR state.

module XcvrResetChan #(
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_req,
  input  logic       i_lock,
  input  logic       i_ack,
  input  logic       i_ready,
  output logic       o_phy_reset,
  output logic       o_done,
  output logic       o_err,
  output logic [2:0] o_state,
  output logic       o_recov
);

  typedef enum logic [2:0] {
    ST_ASSERT     = 3'd1,
    ST_HOLD       = 3'd2,
    ST_RELEASE    = 3'd3,
    ST_WAIT_READY = 3'd4,
    ST_READY      = 3'd5,
    ST_ERROR      = 3'd6
  } state_t;

  if (HOLD_CYCLES < 1 ||
      (64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES) ||
      (64'd1 << CNT_W) <= 64'(HOLD_CYCLES)) begin : g_bad_params
    $error("xcvr_reset_seq: HOLD_CYCLES must be >= 1 and both counts must fit in CNT_W bits");
  end

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_holdCnt;
  logic [CNT_W-1:0] w_holdCntNext;
  logic             r_phyReset;
  logic             r_done;
  logic             w_tmoExpired;
  logic             w_reqRise;

`ifdef XCVR_RST_TIMEOUT_EN
  logic [CNT_W-1:0] r_tmoCnt;
  logic             r_reqQ;
  logic             r_err;

  assign w_tmoExpired = (r_tmoCnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_reqRise    = i_req & ~r_reqQ;
  assign o_err        = r_err;

  // Timeout restarts on every state change and only runs in the ack/ready wait states.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tmoCnt <= '0;
      r_reqQ   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_reqQ <= i_req;
      r_err  <= (w_nextState == ST_ERROR);
      if (w_nextState != r_state)
        r_tmoCnt <= '0;
      else if (r_state inside {ST_ASSERT, ST_RELEASE, ST_WAIT_READY})
        r_tmoCnt <= r_tmoCnt + 1'b1;
      else
        r_tmoCnt <= '0;
    end
  end
`else
  assign w_tmoExpired = 1'b0;
  assign w_reqRise    = 1'b0;
  assign o_err        = 1'b0;
`endif

  always_comb begin
    w_nextState   = r_state;
    w_holdCntNext = r_holdCnt;
    o_recov       = 1'b0;
    case (r_state)
      ST_ASSERT: begin
        if (i_ack) begin
          w_nextState   = ST_HOLD;
          w_holdCntNext = CNT_W'(HOLD_CYCLES - 1);
        end else if (w_tmoExpired) begin
          w_nextState = ST_ERROR;
        end
      end
      ST_HOLD: begin
        if (r_holdCnt != '0)
          w_holdCntNext = r_holdCnt - 1'b1;
        else if (!i_req && i_lock)
          w_nextState = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (i_req)
          w_nextState = ST_ASSERT;
        else if (!i_ack)
          w_nextState = ST_WAIT_READY;
        else if (w_tmoExpired)
          w_nextState = ST_ERROR;
      end
      ST_WAIT_READY: begin
        if (i_req)
          w_nextState = ST_ASSERT;
        else if (i_ready)
          w_nextState = ST_READY;
        else if (w_tmoExpired)
          w_nextState = ST_ERROR;
      end
      ST_READY: begin
        if (i_req) begin
          w_nextState = ST_ASSERT;
        end else if (!i_ready) begin
          w_nextState = ST_ASSERT;
          o_recov     = 1'b1;
        end
      end
      ST_ERROR: begin
        if (w_reqRise)
          w_nextState = ST_ASSERT;
      end
      default: w_nextState = ST_ASSERT;
    endcase
  end

  // Flags are decoded from the next state so they update on the same edge as the state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_ASSERT;
      r_holdCnt  <= '0;
      r_phyReset <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_holdCnt  <= w_holdCntNext;
      r_phyReset <= (w_nextState inside {ST_ASSERT, ST_HOLD, ST_ERROR});
      r_done     <= (w_nextState == ST_READY);
    end
  end

  assign o_phy_reset = r_phyReset;
  assign o_done      = r_done;
  assign o_state     = r_state;

endmodule

module xcvr_reset_seq #(
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tx_req,
  input  logic       i_rx_req,
  input  logic       i_tx_pll_locked,
  input  logic       i_rx_is_lockedtoref,
  input  logic       i_tx_reset_ack,
  input  logic       i_tx_ready,
  input  logic       i_rx_reset_ack,
  input  logic       i_rx_ready,
  output logic       o_phy_tx_reset,
  output logic       o_phy_rx_reset,
  output logic       o_tx_done,
  output logic       o_rx_done,
  output logic       o_tx_err,
  output logic       o_rx_err,
  output logic [2:0] o_tx_state,
  output logic [2:0] o_rx_state,
  output logic [7:0] o_recov_cnt
);

  logic       w_txRecov;
  logic       w_rxRecov;
  logic       w_rxLock;
  logic [8:0] w_recovSum;
  logic [7:0] r_recovCnt;

  // RX may only leave HOLD once TX has fully come up.
  assign w_rxLock = i_rx_is_lockedtoref & o_tx_done;

  XcvrResetChan #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_txChan (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_req      (i_tx_req),
    .i_lock     (i_tx_pll_locked),
    .i_ack      (i_tx_reset_ack),
    .i_ready    (i_tx_ready),
    .o_phy_reset(o_phy_tx_reset),
    .o_done     (o_tx_done),
    .o_err      (o_tx_err),
    .o_state    (o_tx_state),
    .o_recov    (w_txRecov)
  );

  XcvrResetChan #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_rxChan (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_req      (i_rx_req),
    .i_lock     (w_rxLock),
    .i_ack      (i_rx_reset_ack),
    .i_ready    (i_rx_ready),
    .o_phy_reset(o_phy_rx_reset),
    .o_done     (o_rx_done),
    .o_err      (o_rx_err),
    .o_state    (o_rx_state),
    .o_recov    (w_rxRecov)
  );

  // Both channels can lose ready on the same cycle, so the counter may step by two.
  assign w_recovSum = {1'b0, r_recovCnt} + {8'd0, w_txRecov} + {8'd0, w_rxRecov};

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_recovCnt <= 8'd0;
    else
      r_recovCnt <= (w_recovSum > 9'd255) ? 8'hFF : w_recovSum[7:0];
  end

  assign o_recov_cnt = r_recovCnt;

endmodule

// File: doc/xcvr_reset_seq.md
Name: xcvr_reset_seq

Overview:
- Hardware reset sequencer between the CSR conduit controller (software reset request bits, status readback) and the transceiver Native PHY reset conduits.
- Turns level reset requests into PHY-compliant sequences: assert, wait for ack, minimum hold, lock-gated release, wait for ready.
- Runs a power-on sequence automatically out of reset.
- Flags timeouts and auto-recovers on loss of ready.
- TX and RX channels use identical, independent FSMs; RX release is additionally gated on TX being ready.

Parameters:
- HOLD_CYCLES, 16: minimum clk cycles the PHY reset stays asserted after ack, counted in HOLD. Must be ≥1.
- TIMEOUT_CYCLES, 4096: max clk cycles allowed in ASSERT, RELEASE or WAIT_READY before the channel enters ERROR.
- CNT_W, 16: width of hold/timeout counters. Must satisfy 2^CNT_W > max(HOLD_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- tx_req  in  1  level request from CSR control bit 0; 1 = hold TX in reset.
- rx_req  in  1  level request from CSR control bit 1.
- tx_pll_locked  in  1  TX PLL lock; gates TX release.
- rx_is_lockedtoref  in  1  CDR locked to reference; gates RX release.
- tx_reset_ack  in  1  PHY TX reset acknowledge.
- tx_ready  in  1  PHY TX ready.
- rx_reset_ack  in  1  PHY RX reset acknowledge.
- rx_ready  in  1  PHY RX ready.
- phy_tx_reset  out  1  to PHY TX reset.
- phy_rx_reset  out  1  to PHY RX reset.
- tx_done  out  1  TX FSM in READY.
- rx_done  out  1  RX FSM in READY.
- tx_err  out  1  TX FSM in ERROR.
- rx_err  out  1  RX FSM in ERROR.
- tx_state  out  3  TX state encoding.
- rx_state  out  3  RX state encoding.
- recov_cnt  out  8  saturating count of ready-loss recoveries, TX plus RX.

Behaviour:
- State encodings: ASSERT=1, HOLD=2, RELEASE=3, WAIT_READY=4, READY=5, ERROR=6. Encodings 0 and 7 are unused; an FSM in either goes to ASSERT on the next cycle.
- Reset values: both FSMs = ASSERT, phy_*_reset=1, done=0, err=0, counters=0, recov_cnt=0. The power-on sequence starts on the first cycle after reset deasserts.
- All outputs are registered. phy_*_reset=1 in ASSERT, HOLD and ERROR, and 0 otherwise.
- ASSERT: wait for reset_ack=1, then go to HOLD and load the hold counter with HOLD_CYCLES-1.
- HOLD: decrement the counter to 0. Go to RELEASE only when all of these hold in the same cycle:
  - counter==0
  - req==0
  - lock is high (TX: tx_pll_locked; RX: rx_is_lockedtoref AND tx_done)
  - Otherwise stay in HOLD with the counter held at 0. HOLD has no timeout.
- RELEASE: phy reset deasserted. Wait for reset_ack==0, then go to WAIT_READY.
- WAIT_READY: go to READY on ready==1.
- READY: done=1.
  - req==1 → ASSERT.
  - ready==0 with req==0 → ASSERT and recov_cnt+1 (saturates at 255).
  - If both channels drop ready in the same cycle, recov_cnt increments by 2, still saturating.
  - TX leaving READY clears tx_done. RX in RELEASE or WAIT_READY continues; only RX's HOLD exit depends on tx_done.
- Timeout: one counter per channel. It is cleared on every state change and increments in ASSERT, RELEASE and WAIT_READY. When it reaches TIMEOUT_CYCLES-1 without the exit condition, go to ERROR. If the exit condition and expiry occur in the same cycle, the exit wins.
- ERROR: err=1, phy reset=1. Exit to ASSERT only on a rising edge of req (req registered one cycle; the edge is detected against the registered value).
- req==1 in RELEASE or WAIT_READY → ASSERT immediately (abort).
- A reset pulse mid-sequence returns both FSMs to ASSERT within one cycle. No other state is retained.

Optional Feature:
- Macro: XCVR_RST_TIMEOUT_EN.
- Defined: timeout counters and ERROR state are implemented as described above.
- Undefined:
  - No timeout counters are implemented.
  - ASSERT, RELEASE and WAIT_READY wait indefinitely.
  - ERROR is unreachable; tx_err and rx_err are tied to 0.
  - The hold counter is still implemented.

Test Plan:
- Power-on (HOLD_CYCLES=16; locks=1; ack echoes reset after 3 cycles; ready rises 10 cycles after ack falls):
  - phy_tx_reset stays 1 for at least 16 cycles after tx_reset_ack rises.
  - tx_done=1; phy_rx_reset deasserts only after tx_done=1; rx_done=1.
  - recov_cnt=0.
- tx_pll_locked=0 held 100 cycles in HOLD → phy_tx_reset stays 1 and rx stays in HOLD. Lock rises → TX release on the next cycle.
- From READY, tx_req=1 for 1 cycle → tx_state=ASSERT next cycle, full resequence, tx_done returns to 1. recov_cnt unchanged.
- Both in READY, rx_ready dropped for 1 cycle → rx resequences, recov_cnt=1. Drop both ready simultaneously → recov_cnt=3. 260 more drops → recov_cnt=255.
- XCVR_RST_TIMEOUT_EN, TIMEOUT_CYCLES=64, rx_ready never rises:
  - rx_err=1 after 64 cycles in WAIT_READY; phy_rx_reset=1.
  - rx_req held 1 → stays in ERROR; 0→1 edge → ASSERT.
  - Without the macro: remains in WAIT_READY and rx_err=0 after 10000 cycles.
- reset asserted for 1 cycle while TX is in WAIT_READY → next cycle both FSMs=ASSERT, phy_*_reset=1, recov_cnt=0.
